// File: rtl/mac_cluster_pipe_pkg.sv
// Shared definitions for mac_cluster_pipe: mode-word field positions, fusion codes and
// controller states.
package mac_cluster_pipe_pkg;

  localparam int CFG_SIGNED = 3;
  localparam int CFG_MAC    = 2;
  localparam int CFG_FUSION = 0;

  localparam logic [1:0] FUS_SINGLE = 2'b00;
  localparam logic [1:0] FUS_DUAL   = 2'b01;
  localparam logic [1:0] FUS_QUAD   = 2'b10;

  localparam int NUM_FUSION_LEVELS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_pipe_acc_unit.sv
// One fused-group slice: extend the W x W product to AW bits, then accumulate or pass it.
// Saturating accumulation and the sticky flag exist only when MAC_SAT_EN is defined.
module mac_pipe_acc_unit #(
  parameter int W  = 8,
  parameter int AW = 32
) (
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  input  logic [AW-1:0] i_acc,
  input  logic [AW-1:0] i_init,
  input  logic          i_clr,
  input  logic          i_signed,
  input  logic          i_mac,
`ifdef MAC_SAT_EN
  input  logic          i_sat_sticky,
  output logic          o_sat,
`endif
  output logic [AW-1:0] o_acc_next
);

  localparam int PW = 2 * W;
  localparam int EW = AW - PW;

  logic [PW-1:0] w_ext_a;
  logic [PW-1:0] w_ext_b;
  logic [PW-1:0] w_prod;
  logic [AW-1:0] w_prod_ext;
  logic [AW-1:0] w_base;

  // Multiplying operands pre-extended to 2W bits yields the exact signed or unsigned product.
  assign w_ext_a    = i_signed ? {{W{i_a[W-1]}}, i_a} : {{W{1'b0}}, i_a};
  assign w_ext_b    = i_signed ? {{W{i_b[W-1]}}, i_b} : {{W{1'b0}}, i_b};
  assign w_prod     = w_ext_a * w_ext_b;
  assign w_prod_ext = {{EW{i_signed & w_prod[PW-1]}}, w_prod};
  assign w_base     = i_clr ? i_init : i_acc;

`ifdef MAC_SAT_EN
  logic [AW:0]   w_sum;
  logic          w_ovf_s;
  logic          w_ovf;
  logic [AW-1:0] w_sat_val;

  assign w_sum     = {1'b0, w_base} + {1'b0, w_prod_ext};
  assign w_ovf_s   = (w_base[AW-1] == w_prod_ext[AW-1]) && (w_sum[AW-1] != w_base[AW-1]);
  assign w_ovf     = i_signed ? w_ovf_s : w_sum[AW];
  assign w_sat_val = !i_signed    ? {AW{1'b1}} :
                     w_base[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};

  assign o_acc_next = !i_mac ? w_prod_ext : (w_ovf ? w_sat_val : w_sum[AW-1:0]);
  assign o_sat      = i_mac & ((~i_clr & i_sat_sticky) | w_ovf);
`else
  logic [AW-1:0] w_sum;

  assign w_sum      = w_base + w_prod_ext;
  assign o_acc_next = i_mac ? w_sum : w_prod_ext;
`endif

endmodule

// File: rtl/mac_cluster_pipe.sv
// Pipelined fusable MAC cluster with operand/result/config handshakes and a drain-then-load
// reconfiguration controller. Define MAC_SAT_EN for saturating accumulation and out_sat.
module mac_cluster_pipe
  import mac_cluster_pipe_pkg::*;
#(
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int NUM_LANES      = 4,
  parameter int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH,
  parameter int MAC_CONF_WIDTH = 4,
  parameter int PIPE_STAGES    = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [MAC_CONF_WIDTH-1:0]          cfg_mode,
  input  logic [NUM_LANES*MAC_ACC_WIDTH-1:0] cfg_acc_init,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_clr,
  input  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] in_a,
  input  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] in_b,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_LANES*MAC_ACC_WIDTH-1:0] out_data
`ifdef MAC_SAT_EN
  ,
  output logic [NUM_LANES-1:0]               out_sat
`endif
);

  localparam int DW = NUM_LANES * MAC_ACC_WIDTH;

  state_e                    r_state;
  logic [MAC_CONF_WIDTH-1:0] r_mode;
  logic [DW-1:0]             r_init;
  logic [DW-1:0]             r_acc;
  logic [DW-1:0]             r_pipe_data [PIPE_STAGES];
  logic [PIPE_STAGES-1:0]    r_pipe_vld;

  logic                      w_stall;
  logic                      w_accept;
  logic                      w_signed;
  logic                      w_mac;
  logic [1:0]                w_fusion;
  logic [DW-1:0]             w_acc_next;
  logic [NUM_FUSION_LEVELS-1:0][DW-1:0] w_next_lvl;

`ifdef MAC_SAT_EN
  logic [NUM_LANES-1:0]      r_sat;
  logic [NUM_LANES-1:0]      r_pipe_sat [PIPE_STAGES];
  logic [NUM_LANES-1:0]      w_sat_next;
  logic [NUM_FUSION_LEVELS-1:0][NUM_LANES-1:0] w_sat_lvl;

  assign out_sat = r_pipe_sat[PIPE_STAGES-1];
`endif

  assign out_valid = r_pipe_vld[PIPE_STAGES-1];
  assign out_data  = r_pipe_data[PIPE_STAGES-1];
  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = (r_state == ST_RUN) & ~w_stall;
  assign cfg_ready = (r_state == ST_LOAD);
  assign w_accept  = in_valid & in_ready;

  assign w_signed  = r_mode[CFG_SIGNED];
  assign w_mac     = r_mode[CFG_MAC];
  assign w_fusion  = r_mode[CFG_FUSION +: 2];

  // Every fusion level is computed in parallel; the active mode picks one below.
  for (genvar fi = 0; fi < NUM_FUSION_LEVELS; fi++) begin : g_lvl
    localparam int F = 1 << fi;
    for (genvar g = 0; g < NUM_LANES / F; g++) begin : g_grp
      localparam int LO = g * F;
`ifdef MAC_SAT_EN
      logic w_sat_g;
      assign w_sat_lvl[fi][LO +: F] = {F{w_sat_g}};
`endif
      mac_pipe_acc_unit #(
        .W  (F * MAC_MIN_WIDTH),
        .AW (F * MAC_ACC_WIDTH)
      ) u_acc (
        .i_a          (in_a[LO*MAC_MIN_WIDTH +: F*MAC_MIN_WIDTH]),
        .i_b          (in_b[LO*MAC_MIN_WIDTH +: F*MAC_MIN_WIDTH]),
        .i_acc        (r_acc[LO*MAC_ACC_WIDTH +: F*MAC_ACC_WIDTH]),
        .i_init       (r_init[LO*MAC_ACC_WIDTH +: F*MAC_ACC_WIDTH]),
        .i_clr        (in_clr),
        .i_signed     (w_signed),
        .i_mac        (w_mac),
`ifdef MAC_SAT_EN
        .i_sat_sticky (r_sat[LO]),
        .o_sat        (w_sat_g),
`endif
        .o_acc_next   (w_next_lvl[fi][LO*MAC_ACC_WIDTH +: F*MAC_ACC_WIDTH])
      );
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_acc_next = w_next_lvl[0];
`ifdef MAC_SAT_EN
    w_sat_next = w_sat_lvl[0];
`endif
    case (w_fusion)
      FUS_DUAL: begin
        w_acc_next = w_next_lvl[1];
`ifdef MAC_SAT_EN
        w_sat_next = w_sat_lvl[1];
`endif
      end
      FUS_QUAD: begin
        w_acc_next = w_next_lvl[2];
`ifdef MAC_SAT_EN
        w_sat_next = w_sat_lvl[2];
`endif
      end
      FUS_SINGLE: ;
      default: ;
    endcase
  end

  // Controller, mode/init shadows and accumulators share one block: LOAD and beat accept
  // both write the accumulators but can never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= '0;
      r_init  <= '0;
      r_acc   <= '0;
`ifdef MAC_SAT_EN
      r_sat   <= '0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register in the
      // design samples the values from before this edge.
      if (w_accept) begin
        r_acc <= w_acc_next;
`ifdef MAC_SAT_EN
        r_sat <= w_sat_next;
`endif
      end
      case (r_state)
        ST_IDLE:  if (cfg_valid) r_state <= ST_LOAD;
        ST_RUN:   if (cfg_valid) r_state <= ST_DRAIN;
        ST_DRAIN: if (~|r_pipe_vld) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_state <= ST_RUN;
`ifdef MAC_SAT_EN
          r_sat   <= '0;
`endif
          if (cfg_valid) begin
            r_mode <= cfg_mode;
            r_init <= cfg_acc_init;
            r_acc  <= cfg_acc_init;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result pipeline: shifts whenever the output is not stalled, bubbles included, so the
  // accept-to-result latency is constant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      // NOTE: the stage array is reset explicitly because out_data must read zero out of reset.
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_pipe_data[k] <= '0;
`ifdef MAC_SAT_EN
        r_pipe_sat[k]  <= '0;
`endif
      end
    end else if (!w_stall) begin
      r_pipe_vld[0] <= w_accept;
      if (w_accept) begin
        r_pipe_data[0] <= w_acc_next;
`ifdef MAC_SAT_EN
        r_pipe_sat[0]  <= w_sat_next;
`endif
      end
      for (int k = PIPE_STAGES - 1; k > 0; k--) begin
        r_pipe_vld[k]  <= r_pipe_vld[k-1];
        r_pipe_data[k] <= r_pipe_data[k-1];
`ifdef MAC_SAT_EN
        r_pipe_sat[k]  <= r_pipe_sat[k-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_mac_cluster_pipe.sv
// Scoreboard bench for mac_cluster_pipe (MIN=8, 4 lanes, ACC=32, 2 stages); expectations
// adapt to MAC_SAT_EN.
module tb_mac_cluster_pipe;

  localparam int MIN = 8;
  localparam int NL  = 4;
  localparam int ACC = 32;
  localparam int PS  = 2;
  localparam int DW  = NL * ACC;
  localparam int OW  = NL * MIN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [3:0]    cfg_mode = '0;
  logic [DW-1:0] cfg_acc_init = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_clr = 1'b0;
  logic [OW-1:0] in_a = '0;
  logic [OW-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
`ifdef MAC_SAT_EN
  logic [NL-1:0] out_sat;
`endif

  always #5 clk = ~clk;

  mac_cluster_pipe #(
    .MAC_MIN_WIDTH  (MIN),
    .NUM_LANES      (NL),
    .MAC_ACC_WIDTH  (ACC),
    .MAC_CONF_WIDTH (4),
    .PIPE_STAGES    (PS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_mode     (cfg_mode),
    .cfg_acc_init (cfg_acc_init),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_clr       (in_clr),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef MAC_SAT_EN
    ,
    .out_sat      (out_sat)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [NL-1:0] sat;
    int            cyc;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t mon_item;
  int       n_cmp = 0;
  int       n_err = 0;
  int       cyc = 0;
  bit       mon_en = 1'b1;
  bit       lat_chk = 1'b0;
  string    tag = "reset";

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every handshaken result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && mon_en && out_valid && out_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL %s unexpected_result: got %h, required no output", tag, out_data);
      end else begin
        mon_item = sb_q.pop_front();
        if (out_data !== mon_item.data) begin
          n_err++;
          $display("FAIL %s out_data: got %h, required %h", tag, out_data, mon_item.data);
        end
`ifdef MAC_SAT_EN
        n_cmp++;
        if (out_sat !== mon_item.sat) begin
          n_err++;
          $display("FAIL %s out_sat: got %b, required %b", tag, out_sat, mon_item.sat);
        end
`endif
        if (lat_chk) begin
          n_cmp++;
          if (cyc !== mon_item.cyc) begin
            n_err++;
            $display("FAIL %s latency: result at cycle %0d, required %0d", tag, cyc, mon_item.cyc);
          end
        end
      end
    end
  end

  // Offer one configuration and hold it until accepted; ok is cleared on timeout.
  task automatic configure(input logic [3:0] mode, input logic [DW-1:0] init, output bit ok);
    cfg_valid    = 1'b1;
    cfg_mode     = mode;
    cfg_acc_init = init;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  // Offer one beat and push its expected result once the DUT is seen accepting it.
  task automatic send_beat(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic clr,
                           input logic [DW-1:0] exp_data, input logic [NL-1:0] exp_sat,
                           output bit ok);
    sb_item_t it;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_clr   = clr;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        it.data = exp_data;
        it.sat  = exp_sat;
        it.cyc  = cyc + PS;
        sb_q.push_back(it);
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tag = "reset";
    #12;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
    if (out_data !== '0) begin n_err++; $display("FAIL reset out_data: got %h, required 0", out_data); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset in_ready: got %b, required 0", in_ready); end
    if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset cfg_ready: got %b, required 0", cfg_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_mac;
    bit ok;
    tag = "single_mac";
    configure(4'b0100, '0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_mac cfg_accept: got timeout, required cfg_ready"); end
    lat_chk = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      send_beat({4{8'd3}}, {4{8'd5}}, 1'b0, {4{32'(15 * i)}}, '0, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL single_mac accept: got timeout, required in_ready"); end
    end
    in_valid = 1'b0;
    wait_empty(20, ok);
    lat_chk = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_mac drain: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_fusion_mul;
    bit ok;
    tag = "dual_signed_mul";
    configure(4'b1001, '0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL dual_signed_mul cfg_accept: got timeout, required cfg_ready"); end
    send_beat({16'h0100, 16'hFFFE}, {16'hFF00, 16'h0003}, 1'b0,
              {32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFFFFFF, 32'hFFFFFFFA}, '0, ok);
    in_valid = 1'b0;
    wait_empty(20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL dual_signed_mul drain: got %0d pending, required 0", sb_q.size()); end

    tag = "quad_unsigned_mul";
    configure(4'b0010, '0, ok);
    send_beat(32'hFFFFFFFF, 32'h00000002, 1'b0,
              {32'h0, 32'h0, 32'h1, 32'hFFFFFFFE}, '0, ok);
    in_valid = 1'b0;
    wait_empty(20, ok);

    tag = "fusion11_as_single";
    configure(4'b0011, '0, ok);
    send_beat({4{8'hFF}}, {4{8'hFF}}, 1'b0, {4{32'h0000FE01}}, '0, ok);
    in_valid = 1'b0;
    wait_empty(20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL fusion11_as_single drain: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_backpressure;
    bit ok;
    tag = "backpressure";
    configure(4'b0000, '0, ok);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [OW-1:0] a;
          logic [DW-1:0] e;
          bit            sok;
          for (int l = 0; l < NL; l++) begin
            a[l*MIN +: MIN] = 8'(i + 1 + l);
            e[l*ACC +: ACC] = 32'(3 * (i + 1 + l));
          end
          send_beat(a, {4{8'd3}}, 1'b0, e, '0, sok);
          n_cmp++;
          if (!sok) begin n_err++; $display("FAIL backpressure accept: got timeout at beat %0d, required in_ready", i); end
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_cmp++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure stall: got in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_empty(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL backpressure drain: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_reconfig;
    bit ok;
    bit seen;
    tag = "reconfig";
    configure(4'b0100, '0, ok);
    send_beat({4{8'd2}}, {4{8'd2}}, 1'b0, {4{32'd4}}, '0, ok);
    send_beat({4{8'd1}}, {4{8'd1}}, 1'b0, {4{32'd5}}, '0, ok);
    in_valid     = 1'b0;
    cfg_valid    = 1'b1;
    cfg_mode     = 4'b0100;
    cfg_acc_init = {4{32'd100}};
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        seen = 1'b1;
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reconfig cfg_ready_early: got out_valid=%b, required 0", out_valid); end
        if (sb_q.size() != 0) begin n_err++; $display("FAIL reconfig old_beats: got %0d pending, required 0", sb_q.size()); end
        break;
      end
      if (i > 0) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reconfig drain_in_ready: got %b, required 0", in_ready); end
      end
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL reconfig cfg_accept: got timeout, required cfg_ready"); end
    send_beat({4{8'd1}}, {4{8'd1}}, 1'b0, {4{32'd101}}, '0, ok);
    in_valid = 1'b0;
    wait_empty(20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL reconfig drain: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_async_reset;
    bit ok;
    tag = "async_reset";
    configure(4'b0000, '0, ok);
    mon_en   = 1'b0;
    in_valid = 1'b1;
    in_a     = {4{8'd2}};
    in_b     = {4{8'd2}};
    in_clr   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL async_reset streaming: got out_valid=%b, required 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_reset out_valid: got %b, required 0", out_valid); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL async_reset in_ready: got %b, required 0", in_ready); end
    if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL async_reset cfg_ready: got %b, required 0", cfg_ready); end
    sb_q.delete();
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL async_reset post_release: got out_valid=%b in_ready=%b, required 0/0", out_valid, in_ready);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_saturation;
    bit ok;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [NL-1:0] s0;
    tag = "saturation";
    configure(4'b1100, {4{32'h7FFFFFF0}}, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL saturation cfg_accept: got timeout, required cfg_ready"); end
`ifdef MAC_SAT_EN
    e0 = {4{32'h7FFFFFFF}};
    e1 = {4{32'h7FFFFFFF}};
    s0 = 4'hF;
`else
    e0 = {4{32'h80003EF1}};
    e1 = {4{32'h80003EF1}};
    s0 = 4'h0;
`endif
    send_beat({4{8'h7F}}, {4{8'h7F}}, 1'b0, e0, s0, ok);
    send_beat({4{8'h00}}, {4{8'h00}}, 1'b0, e1, s0, ok);
    send_beat({4{8'h01}}, {4{8'h01}}, 1'b1, {4{32'h7FFFFFF1}}, 4'h0, ok);
    in_valid = 1'b0;
    in_clr   = 1'b0;
    wait_empty(20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL saturation drain: got %0d pending, required 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_mac();
    test_fusion_mul();
    test_backpressure();
    test_reconfig();
    test_async_reset();
    test_saturation();
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mac_cluster_pipe.md
Name: mac_cluster_pipe

Overview:
- Parametrised, fully pipelined successor to the quad MAC cluster.
- NUM_LANES minimum-width lanes can be fused into single/dual/quad-precision groups. Each group multiplies and then accumulates or just multiplies, signed or unsigned.
- Adds valid/ready handshakes on operands, results and configuration, plus a drain-then-reconfigure state machine and per-beat accumulator clear.
- Sits between the operand fabric and the result router in place of the fixed-latency cluster.

Parameters:
- MAC_MIN_WIDTH, 8: lane operand width.
- NUM_LANES, 4: lane count; power of 2, at least 4.
- MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH: per-lane accumulator width.
- MAC_CONF_WIDTH, 4: mode word width.
- PIPE_STAGES, 2: accept-to-result latency; at least 1.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- cfg_valid, in, 1: configuration offered.
- cfg_ready, out, 1: configuration accepted this cycle when cfg_valid is also high.
- cfg_mode, in, MAC_CONF_WIDTH: bit [3] signed; bit [2] mac(1)/mul(0); bits [1:0] fusion (00 single, 01 dual, 10 quad, 11 treated as single).
- cfg_acc_init, in, NUM_LANES*MAC_ACC_WIDTH: accumulator initial value, sliced per group.
- in_valid, in, 1: operand beat valid.
- in_ready, out, 1: operand beat accepted.
- in_clr, in, 1: this beat restarts each accumulator from its init value.
- in_a, in, NUM_LANES*MAC_MIN_WIDTH: A operands, lane 0 in the LSBs.
- in_b, in, NUM_LANES*MAC_MIN_WIDTH: B operands.
- out_valid, out, 1: result valid.
- out_ready, in, 1: result consumed.
- out_data, out, NUM_LANES*MAC_ACC_WIDTH: per-lane results.
- out_sat, out, NUM_LANES: saturation flags; present only when MAC_SAT_EN is defined.

Behaviour:
- Reset (asynchronous, active-low):
  - State is IDLE.
  - mode = 0000; all accumulators and init shadow registers = 0.
  - All pipeline valid bits = 0.
  - out_valid = 0, out_data = 0, in_ready = 0, cfg_ready = 0.
- Fusion F = 1, 2 or 4. Group g covers lanes g*F .. g*F+F-1.
  - A_g = in_a[g*F*MIN +: F*MIN], B_g likewise.
  - Product has 2F*MIN bits; it is sign-extended (signed mode) or zero-extended to F*ACC bits.
- Accumulator update per group, modulo 2^(F*ACC):
  - mac mode: acc_g <= (in_clr ? init_g : acc_g) + prod_g.
  - mul mode: acc_g <= prod_g.
  - out_data for group g is acc_g after the update, spread across the group's lanes, low lane in the LSBs.
- Latency: a beat accepted at cycle t drives out_valid at t+PIPE_STAGES when there is no backpressure. Beats stay in order and are never dropped or duplicated.
- Stall: stall = out_valid & ~out_ready.
  - A stall freezes the whole pipeline, including the accumulators.
  - in_ready = (state==RUN) & ~stall.
- FSM:
  - IDLE: in_ready = 0. cfg_valid -> LOAD.
  - RUN: cfg_valid -> DRAIN.
  - DRAIN: in_ready = 0. When all pipeline valid bits are 0 and out_valid = 0 -> LOAD.
  - LOAD (1 cycle): cfg_ready = 1. Latch cfg_mode, copy cfg_acc_init into the init shadow and the accumulators, then -> RUN. If cfg_valid has dropped, go -> RUN with mode unchanged (protocol requires cfg_valid held until accepted).
- Beats in flight when reconfiguration starts complete under the old mode.
- Reset mid-operation discards in-flight beats with no output.

Optional Feature:
- MAC_SAT_EN defined:
  - mac-mode accumulation saturates to the group's F*ACC-bit signed max/min, or unsigned max in unsigned mode.
  - out_sat is asserted on all lanes of a saturated group. It is sticky until an in_clr beat or a LOAD, and travels with out_data.
- MAC_SAT_EN undefined: arithmetic wraps modulo 2^(F*ACC) and out_sat does not exist.
- mul mode never saturates: the product always fits in F*ACC bits.

Decomposition:
- mac_const.vh holds:
  - cfg bit positions (CFG_SIGNED, CFG_MAC, CFG_FUSION);
  - fusion codes;
  - FSM state encodings (IDLE, RUN, DRAIN, LOAD).
- Sub-module mac_pipe_acc_unit: one group-width extend/accumulate/saturate slice, parametrised by group width, instantiated with generate per fusion level. A mux selects by mode.

Test Plan (MIN=8, NUM_LANES=4, ACC=32, PIPE_STAGES=2):
1. Reset; configure unsigned single mac with init 0; 3 beats of A=3, B=5 on all lanes -> each lane outputs 15, 30, 45 at accept+2.
2. Signed dual mul; group 0 A=16'hFFFE, B=16'h0003 -> lane 0 = 32'hFFFFFFFA, lane 1 = 32'hFFFFFFFF (that is, -6).
3. Continuous in_valid with out_ready low for 5 cycles -> in_ready low during the stall; after release the sequence is complete, in order, with no duplicates.
4. cfg_valid raised with 2 beats in flight -> both emerge in old mode; cfg_ready pulses only after out_valid = 0; the next result starts from the new init 100.
5. rst_n asserted mid-stream, asynchronously -> out_valid = 0 and in_ready = 0 immediately; state IDLE; no results after release until configured.
6. Signed single mac, init 32'h7FFFFFF0, A=B=127 -> with MAC_SAT_EN: 32'h7FFFFFFF and out_sat = 1; without: 32'h80003EF1.
